// File: rtl/exp16.sv
`default_nettype none
// ============================================================================
// Module   : exp16
// Purpose  : Expander for rectangular X/Y sample streams. The magnitude
//            estimate max(|x|,|y|) + min(|x|,|y|)/2 is built from the high
//            bytes and selects a 4.4 unsigned gain from a 64x8 table that is
//            loaded serially. X and Y are then scaled through a shared
//            8-step shift-add multiplier and saturated back to 16 bits.
// Ports    : clk        system clock, rising edge
//            rstn       asynchronous active-low reset (gain table not reset)
//            dix, diy   signed 16-bit input samples, qualified by iv
//            iv         input valid
//            rdy        high when idle and able to accept iv
//            dox, doy   expanded signed outputs, held until the next ov
//            ov         one-clock output valid pulse
//            ovr        sticky overrun flag (iv seen while rdy=0)
//            cin, cwe   gain table shift-in data / shift enable
// Revision : 1.0 - initial release
// ============================================================================
module exp16 (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] dix,
    input  logic [15:0] diy,
    input  logic        iv,
    output logic        rdy,
    output logic [15:0] dox,
    output logic [15:0] doy,
    output logic        ov,
    output logic        ovr,
    input  logic [7:0]  cin,
    input  logic        cwe
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAG  = 3'd1,
        S_LUT  = 3'd2,
        S_MUL  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [7:0]  tab [64];

    logic [15:0] dx;
    logic [15:0] dy;
    logic [6:0]  ax;
    logic [6:0]  ay;
    logic [5:0]  idx;
    logic [7:0]  gain;
    logic [2:0]  cnt;
    logic [23:0] accx;
    logic [23:0] accy;

    logic [6:0]  mx;
    logic [6:0]  mn;
    logic [7:0]  mag;
    logic [5:0]  idx_nx;
    logic [23:0] dx_ext;
    logic [23:0] dy_ext;
    logic [23:0] accx_nx;
    logic [23:0] accy_nx;

    // |b| for a signed byte, with -128 clamped to 127 so it fits 7 bits.
    function automatic logic [6:0] abs_sat(input logic [7:0] b);
        logic [7:0] n;
        n = ~b + 8'd1;
        if (!b[7])
            return b[6:0];
        else if (b == 8'h80)
            return 7'h7F;
        else
            return n[6:0];
    endfunction

    // acc >>> 4 is a 20-bit value; it fits 16 bits only when bits 23..19 agree.
    function automatic logic [15:0] sat16(input logic [23:0] acc);
        if ((acc[23:19] == 5'b00000) || (acc[23:19] == 5'b11111))
            return acc[19:4];
        else if (acc[23])
            return 16'h8000;
        else
            return 16'h7FFF;
    endfunction

    assign rdy = (state == S_IDLE);

    // Gain table: a plain shift register, honoured in every state and left
    // untouched by reset so a loaded table survives a reset.
    always_ff @(posedge clk) begin
        if (cwe) begin
            tab[0] <= cin;
            for (int a = 1; a < 64; a++) begin
                tab[a] <= tab[a-1];
            end
        end
    end

    always_comb begin
        mx     = (ax > ay) ? ax : ay;
        mn     = (ax > ay) ? ay : ax;
        mag    = {1'b0, mx} + 8'(mn >> 1);
        idx_nx = (mag > 8'd127) ? 6'd63 : 6'(mag >> 1);
    end

    always_comb begin
        dx_ext  = {{8{dx[15]}}, dx};
        dy_ext  = {{8{dy[15]}}, dy};
        accx_nx = accx + (gain[cnt] ? (dx_ext << cnt) : 24'd0);
        accy_nx = accy + (gain[cnt] ? (dy_ext << cnt) : 24'd0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (iv) state_nx = S_MAG;
            S_MAG:   state_nx = S_LUT;
            S_LUT:   state_nx = S_MUL;
            S_MUL:   if (cnt == 3'd7) state_nx = S_OUT;
            S_OUT:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dx   <= '0;
            dy   <= '0;
            ax   <= '0;
            ay   <= '0;
            idx  <= '0;
            gain <= '0;
            cnt  <= '0;
            accx <= '0;
            accy <= '0;
            dox  <= '0;
            doy  <= '0;
            ov   <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            ov <= 1'b0;
            if (iv && !rdy)
                ovr <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (iv) begin
                        dx <= dix;
                        dy <= diy;
                        ax <= abs_sat(dix[15:8]);
                        ay <= abs_sat(diy[15:8]);
                    end
                end
                S_MAG: begin
                    idx <= idx_nx;
                end
                S_LUT: begin
                    // Captures the pre-shift entry if cwe is active on this edge.
                    gain <= tab[idx];
                    cnt  <= 3'd0;
                    accx <= '0;
                    accy <= '0;
                end
                S_MUL: begin
                    accx <= accx_nx;
                    accy <= accy_nx;
                    cnt  <= cnt + 3'd1;
                    // Final step: register the saturated result so it is
                    // visible, with ov, throughout the OUT cycle.
                    if (cnt == 3'd7) begin
                        dox <= sat16(accx_nx);
                        doy <= sat16(accy_nx);
                        ov  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exp16.sv
`default_nettype none
// ============================================================================
// Module   : tb_exp16
// Purpose  : Self-checking bench for exp16. Expected results are pushed to a
//            scoreboard queue when a sample is driven and popped when ov
//            fires. A reference model of the gain table and the expansion
//            arithmetic (plain integer multiply) produces table-driven
//            expectations; the documented scenarios use constant results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exp16;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] dix;
    logic [15:0] diy;
    logic        iv;
    logic        rdy;
    logic [15:0] dox;
    logic [15:0] doy;
    logic        ov;
    logic        ovr;
    logic [7:0]  cin;
    logic        cwe;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tab_m [64];
    logic [31:0] sb [$];

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] ex;
        logic [15:0] ey;
    } vec_t;

    vec_t vt [10];

    exp16 dut (
        .clk  (clk),
        .rstn (rstn),
        .dix  (dix),
        .diy  (diy),
        .iv   (iv),
        .rdy  (rdy),
        .dox  (dox),
        .doy  (doy),
        .ov   (ov),
        .ovr  (ovr),
        .cin  (cin),
        .cwe  (cwe)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int hmag(input logic [15:0] v);
        int h;
        h = int'($signed(v[15:8]));
        if (h < 0) h = -h;
        if (h > 127) h = 127;
        return h;
    endfunction

    function automatic logic [7:0] gain_for(input logic [15:0] x, input logic [15:0] y);
        int a, b, mx, mn, m, ix;
        a  = hmag(x);
        b  = hmag(y);
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        m  = mx + mn / 2;
        ix = (m > 127) ? 63 : m / 2;
        return tab_m[ix];
    endfunction

    function automatic logic [15:0] scale(input logic [15:0] v, input logic [7:0] g);
        int p;
        p = int'($signed(v)) * int'({24'd0, g});
        p = p >>> 4;
        if (p > 32767) return 16'h7FFF;
        if (p < -32768) return 16'h8000;
        return p[15:0];
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic shift_in(input logic [7:0] v);
        cwe = 1'b1;
        cin = v;
        for (int a = 63; a > 0; a--) tab_m[a] = tab_m[a-1];
        tab_m[0] = v;
        @(negedge clk);
        cwe = 1'b0;
    endtask

    task automatic load_const(input logic [7:0] v);
        repeat (64) shift_in(v);
    endtask

    // Drive one sample and check latency, pulse width and the scoreboard.
    // nwr table writes of wv are issued from the LUT-edge clock onward;
    // dup re-asserts iv three clocks after the accepted sample.
    task automatic run(input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] ex, input logic [15:0] ey,
                       input int nwr, input logic [7:0] wv,
                       input bit dup, input string nm);
        int t;
        int n;
        logic [31:0] e;
        t = 0;
        while (!rdy && t < 30) begin
            @(negedge clk);
            t++;
        end
        sb.push_back({ey, ex});
        dix = x;
        diy = y;
        iv  = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        n  = 1;
        while (!ov && n < 20) begin
            if (dup && n == 3) begin
                iv  = 1'b1;
                dix = ~x;
                diy = ~y;
            end else begin
                iv = 1'b0;
            end
            if (n >= 2 && n < 2 + nwr) begin
                cwe = 1'b1;
                cin = wv;
                for (int a = 63; a > 0; a--) tab_m[a] = tab_m[a-1];
                tab_m[0] = wv;
            end else begin
                cwe = 1'b0;
            end
            if (n == 5) check({nm, "_rdy_busy"}, {31'd0, rdy}, 32'd0);
            @(negedge clk);
            n++;
        end
        iv  = 1'b0;
        cwe = 1'b0;
        check({nm, "_latency"}, n, 32'd11);
        e = sb.pop_front();
        check({nm, "_out"}, {doy, dox}, e);
        @(negedge clk);
        check({nm, "_ov_pulse"}, {31'd0, ov}, 32'd0);
    endtask

    initial begin
        int seen;
        logic [7:0] g;

        rstn = 1'b0;
        dix  = '0;
        diy  = '0;
        iv   = 1'b0;
        cin  = '0;
        cwe  = 1'b0;
        for (int a = 0; a < 64; a++) tab_m[a] = 8'h00;

        vt[0] = '{16'h4000, 16'h0000, 16'h0, 16'h0};
        vt[1] = '{16'h0100, 16'h0100, 16'h0, 16'h0};
        vt[2] = '{16'h7FFF, 16'h0000, 16'h0, 16'h0};
        vt[3] = '{16'hC000, 16'h2000, 16'h0, 16'h0};
        vt[4] = '{16'h0800, 16'hF800, 16'h0, 16'h0};
        vt[5] = '{16'h1000, 16'hFFFF, 16'h0, 16'h0};
        vt[6] = '{16'h8000, 16'h7F00, 16'h0, 16'h0};
        vt[7] = '{16'h0300, 16'hFD00, 16'h0, 16'h0};
        vt[8] = '{16'($urandom), 16'($urandom), 16'h0, 16'h0};
        vt[9] = '{16'($urandom), 16'($urandom), 16'h0, 16'h0};

        repeat (3) @(negedge clk);
        check("rst_state", {dox, doy}, 32'd0);
        check("rst_flags", {29'd0, rdy, ov, ovr}, 32'b100);
        rstn = 1'b1;
        @(negedge clk);

        // Unity table
        load_const(8'h10);
        run(16'h1234, 16'hFF00, 16'h1234, 16'hFF00, 0, 8'h00, 1'b0, "t1_unity");

        // Second iv while busy is dropped and sets the sticky flag
        run(16'h0500, 16'h0700, 16'h0500, 16'h0700, 0, 8'h00, 1'b1, "t5_first");
        check("t5_ovr_set", {31'd0, ovr}, 32'd1);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (ov) seen++;
        end
        check("t5_no_second_ov", seen, 32'd0);
        run(16'h0100, 16'h0200, 16'h0100, 16'h0200, 0, 8'h00, 1'b0, "t5_after");
        check("t5_ovr_sticky", {31'd0, ovr}, 32'd1);

        // Reset during MUL aborts the sample; table survives
        dix = 16'h2222;
        diy = 16'h3333;
        iv  = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("t6_rst_out", {dox, doy}, 32'd0);
        check("t6_rst_flags", {29'd0, rdy, ov, ovr}, 32'b100);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (ov) seen++;
        end
        check("t6_no_ov", seen, 32'd0);
        run(16'h1234, 16'hFF00, 16'h1234, 16'hFF00, 0, 8'h00, 1'b0, "t6_unity");

        // Ramp table tab[a] = a
        for (int n = 0; n < 64; n++) shift_in(8'(63 - n));
        run(16'h4000, 16'h0000, 16'h7FFF, 16'h0000, 0, 8'h00, 1'b0, "t2_ramp_sat");

        for (int i = 0; i < 10; i++) begin
            g = gain_for(vt[i].x, vt[i].y);
            vt[i].ex = scale(vt[i].x, g);
            vt[i].ey = scale(vt[i].y, g);
        end
        for (int i = 0; i < 10; i++) begin
            run(vt[i].x, vt[i].y, vt[i].ex, vt[i].ey, 0, 8'h00, 1'b0, $sformatf("vec%0d", i));
        end

        // Writes from the LUT edge onward must not disturb the sample in flight
        run(16'h4000, 16'h0000, 16'h7FFF, 16'h0000, 3, 8'h00, 1'b0, "inflight_wr");
        run(16'h4000, 16'h0000, 16'h7400, 16'h0000, 0, 8'h00, 1'b0, "after_wr");

        // tab[0] = 0.25, rest unity
        repeat (63) shift_in(8'h10);
        shift_in(8'h04);
        run(16'h0040, 16'hFFC0, 16'h0010, 16'hFFF0, 0, 8'h00, 1'b0, "t4_quarter");

        // Max gain, negative full scale
        load_const(8'hFF);
        run(16'h8000, 16'h8000, 16'h8000, 16'h8000, 0, 8'h00, 1'b0, "t3_negsat");
        check("t3_ovr_clear", {31'd0, ovr}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
